// File: rtl/wavetable_server_pkg.sv
// Shared widths and FSM encoding for the wavetable lookup server.
package wavetable_server_pkg;

  localparam int PHASE_W  = 7;
  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/wavetable_ram.sv
// Single-port synchronous wavetable RAM. The read register only updates on an
// explicit read, so a later write cannot disturb data already fetched.
module wavetable_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write has priority on the single port; a read only happens when no write is present.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wavetable_server.sv
// Wavetable lookup server: per-voice request slots, round-robin arbiter and a
// three-state read sequencer sharing one RAM port with the host writer.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | waiting; grants next pending voice and launches its RAM read
//   ST_ISSUE   | RAM read data registered, held stable for the capture step
//   ST_CAPTURE | load selected voice sample, pulse its strobe, move rr pointer
module wavetable_server
  import wavetable_server_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int WAVES  = 4,
  parameter int WSEL_W = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [VOICES-1:0]          REQ,
  input  logic [VOICES*PHASE_W-1:0]  PHASE_IN,
  input  logic [VOICES*WSEL_W-1:0]   WAVE_SEL,
  input  logic                       WR_EN,
  input  logic [WSEL_W+PHASE_W-1:0]  WR_ADDR,
  input  logic [SAMPLE_W-1:0]        WR_DATA,
  output logic [VOICES*SAMPLE_W-1:0] PROG_SAMPLE,
  output logic [VOICES-1:0]          TRIG_SAMPLE
);

  localparam int AW    = WSEL_W + PHASE_W;
  localparam int DEPTH = WAVES * (1 << PHASE_W);
  localparam int VW    = $clog2(VOICES);

  state_e                     state_q, state_d;
  logic [VW-1:0]              sel_q, sel_d;
  logic [VW-1:0]              rr_q, rr_d;
  logic [VOICES-1:0]          pending_q, pending_d;
  logic [AW-1:0]              slot_q [VOICES];
  logic [AW-1:0]              slot_d [VOICES];
  logic [VOICES*SAMPLE_W-1:0] prog_q, prog_d;
  logic [VOICES-1:0]          trig_q, trig_d;

  logic                       grant_found;
  logic [VW-1:0]              grant_idx;
  logic [VW-1:0]              cand;
  logic [VOICES-1:0]          grant_clr;
  logic                       ram_re;
  logic [AW-1:0]              ram_addr;
  logic [SAMPLE_W-1:0]        ram_rdata;

  // Round-robin search: first pending voice strictly after the last one served.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= VOICES; i++) begin
      cand = VW'((int'(rr_q) + i) % VOICES);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Request capture: a new request always re-arms pending and overwrites the slot,
  // even in the same cycle its previous request is granted.
  always_comb begin
    pending_d = (pending_q & ~grant_clr) | REQ;
    for (int v = 0; v < VOICES; v++) begin
      slot_d[v] = slot_q[v];
      if (REQ[v]) begin
        slot_d[v] = {WAVE_SEL[WSEL_W*v +: WSEL_W], PHASE_IN[PHASE_W*v +: PHASE_W]};
      end
    end
  end

  // Read sequencer: grant in IDLE (blocked by a host write), fetch, then deliver.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    prog_d    = prog_q;
    trig_d    = '0;
    grant_clr = '0;
    ram_re    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found && !WR_EN) begin
          ram_re               = 1'b1;
          sel_d                = grant_idx;
          grant_clr[grant_idx] = 1'b1;
          state_d              = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        for (int v = 0; v < VOICES; v++) begin
          if (sel_q == VW'(v)) begin
            prog_d[SAMPLE_W*v +: SAMPLE_W] = ram_rdata;
            trig_d[v]                      = 1'b1;
          end
        end
        rr_d    = sel_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Host writes own the port whenever present; otherwise the granted slot addresses it.
  assign ram_addr = WR_EN ? WR_ADDR : slot_q[grant_idx];

  // State, slots and registered outputs; reset abandons any read in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      rr_q      <= VW'(VOICES - 1);
      pending_q <= '0;
      prog_q    <= '0;
      trig_q    <= '0;
      for (int v = 0; v < VOICES; v++) begin
        slot_q[v] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      prog_q    <= prog_d;
      trig_q    <= trig_d;
      for (int v = 0; v < VOICES; v++) begin
        slot_q[v] <= slot_d[v];
      end
    end
  end

  assign PROG_SAMPLE = prog_q;
  assign TRIG_SAMPLE = trig_q;

  wavetable_ram #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (WR_EN),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (WR_DATA),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_wavetable_server.sv
// Bench for wavetable_server: directed table and sequences plus randomized
// traffic, all compared each cycle against a transaction-level server model.
module tb_wavetable_server;

  localparam int NV = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [27:0] PHASE_IN;
  logic [7:0]  WAVE_SEL;
  logic        WR_EN;
  logic [8:0]  WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [31:0] PROG_SAMPLE;
  logic [3:0]  TRIG_SAMPLE;

  wavetable_server #(.VOICES(4), .WAVES(4), .WSEL_W(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ         (REQ),
    .PHASE_IN    (PHASE_IN),
    .WAVE_SEL    (WAVE_SEL),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .PROG_SAMPLE (PROG_SAMPLE),
    .TRIG_SAMPLE (TRIG_SAMPLE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Server model: a pending set, latest request per voice, a memory image, and a
  // single lookup in flight that completes a fixed time after it is granted.
  bit          m_pend [NV];
  logic [8:0]  m_slot [NV];
  logic [7:0]  m_mem  [512];
  int          m_busy;
  int          m_cur;
  int          m_last;
  logic [7:0]  m_val;
  logic [3:0]  m_trig;
  logic [31:0] m_samp;

  typedef struct {
    int         v;
    int         wave;
    int         phase;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [3:0] nt;
    bit         found;
    int         v;
    nt = '0;
    if (WR_EN) m_mem[WR_ADDR] = WR_DATA;
    if (RST) begin
      for (int k = 0; k < NV; k++) m_pend[k] = 1'b0;
      m_busy = 0;
      m_last = NV - 1;
      m_samp = '0;
      m_trig = '0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_samp[8*m_cur +: 8] = m_val;
        nt[m_cur]            = 1'b1;
        m_last               = m_cur;
      end
    end else if (!WR_EN) begin
      found = 1'b0;
      for (int k = 1; k <= NV; k++) begin
        v = (m_last + k) % NV;
        if (!found && m_pend[v]) begin
          found     = 1'b1;
          m_pend[v] = 1'b0;
          m_cur     = v;
          m_val     = m_mem[m_slot[v]];
          m_busy    = 2;
        end
      end
    end
    for (int k = 0; k < NV; k++) begin
      if (REQ[k]) begin
        m_pend[k] = 1'b1;
        m_slot[k] = {WAVE_SEL[2*k +: 2], PHASE_IN[7*k +: 7]};
      end
    end
    m_trig = nt;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    chk("trig_model", 32'(TRIG_SAMPLE), 32'(m_trig));
    chk("sample_model", PROG_SAMPLE, m_samp);
    chk("single_strobe", 32'($countones(TRIG_SAMPLE) <= 1), 32'd1);
  endtask

  task automatic idle(input int n);
    REQ   = '0;
    WR_EN = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    WR_EN   = 1'b1;
    WR_ADDR = 9'(addr);
    WR_DATA = data;
    tick();
    WR_EN   = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = '0;
    tick();
    RST = 1'b0;
  endtask

  int         strobes;
  logic [7:0] got;
  int         last_s [NV];
  int         cnt_s  [NV];

  initial begin
    RST      = 1'b1;
    REQ      = '0;
    PHASE_IN = '0;
    WAVE_SEL = '0;
    WR_EN    = 1'b0;
    WR_ADDR  = '0;
    WR_DATA  = '0;
    m_busy   = 0;
    m_cur    = 0;
    m_last   = NV - 1;
    m_val    = '0;
    m_trig   = '0;
    m_samp   = '0;

    tick();
    RST = 1'b0;
    chk("reset_samples", PROG_SAMPLE, 32'h0);
    chk("reset_trig", 32'(TRIG_SAMPLE), 32'h0);

    // fill the whole table so every later read has a known value
    for (int a = 0; a < 512; a++) wr(a, 8'($urandom));
    idle(4);

    // single lookups: latency 4 with a single strobe, including address extremes
    tbl[0] = '{0, 0, 5,   8'h40};
    tbl[1] = '{3, 3, 127, 8'hC3};
    tbl[2] = '{1, 0, 0,   8'h01};
    tbl[3] = '{2, 2, 64,  8'hFF};
    tbl[4] = '{0, 1, 100, 8'h00};
    for (int i = 0; i < 5; i++) begin
      idle(4);
      wr(tbl[i].wave * 128 + tbl[i].phase, tbl[i].data);
      REQ                          = 4'(1 << tbl[i].v);
      PHASE_IN[7*tbl[i].v +: 7]    = 7'(tbl[i].phase);
      WAVE_SEL[2*tbl[i].v +: 2]    = 2'(tbl[i].wave);
      tick();
      REQ = '0;
      tick();
      chk("lat_early2", 32'(TRIG_SAMPLE), 32'h0);
      tick();
      chk("lat_early3", 32'(TRIG_SAMPLE), 32'h0);
      tick();
      chk("lat_trig", 32'(TRIG_SAMPLE), 32'(1 << tbl[i].v));
      chk("lat_sample", 32'(PROG_SAMPLE[8*tbl[i].v +: 8]), 32'(tbl[i].data));
      tick();
      chk("lat_pulse_end", 32'(TRIG_SAMPLE), 32'h0);
    end

    // all four voices at once after reset: v0..v3, three cycles apart
    do_reset();
    for (int n = 1; n <= 4; n++) wr(128 + n, 8'(8'h10 + n));
    REQ = 4'hF;
    for (int v = 0; v < NV; v++) begin
      PHASE_IN[7*v +: 7] = 7'(v + 1);
      WAVE_SEL[2*v +: 2] = 2'd1;
    end
    tick();
    REQ = '0;
    for (int c = 2; c <= 13; c++) begin
      tick();
      if (c >= 4 && (c - 4) % 3 == 0) begin
        chk("burst_trig", 32'(TRIG_SAMPLE), 32'(1 << ((c - 4) / 3)));
        chk("burst_sample", 32'(PROG_SAMPLE[8*((c-4)/3) +: 8]), 32'(8'h11 + (c - 4) / 3));
      end else begin
        chk("burst_gap", 32'(TRIG_SAMPLE), 32'h0);
      end
    end

    // coalescing: voice 2 re-requests while still pending behind a write
    idle(4);
    wr(9, 8'h99);
    wr(10, 8'h5A);
    WR_EN = 1'b1; WR_ADDR = 9'(3*128 + 100); WR_DATA = 8'h77;
    REQ = 4'b0100; PHASE_IN[14 +: 7] = 7'd9; WAVE_SEL[4 +: 2] = 2'd0;
    tick();
    PHASE_IN[14 +: 7] = 7'd10;
    tick();
    REQ = '0; WR_EN = 1'b0;
    strobes = 0;
    got     = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (TRIG_SAMPLE[2]) begin
        strobes++;
        got = PROG_SAMPLE[23:16];
      end
    end
    chk("coalesce_count", 32'(strobes), 32'd1);
    chk("coalesce_sample", 32'(got), 32'h5A);

    // write held five cycles delays the grant; the read then sees the new value
    idle(4);
    WR_EN = 1'b1; WR_ADDR = 9'd7; WR_DATA = 8'hAA;
    REQ = 4'b0010; PHASE_IN[7 +: 7] = 7'd7; WAVE_SEL[2 +: 2] = 2'd0;
    tick();
    REQ = '0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("wr_block", 32'(TRIG_SAMPLE), 32'h0);
    end
    WR_EN = 1'b0;
    tick();
    chk("wr_block6", 32'(TRIG_SAMPLE), 32'h0);
    tick();
    chk("wr_block7", 32'(TRIG_SAMPLE), 32'h0);
    tick();
    chk("wr_trig", 32'(TRIG_SAMPLE), 32'h2);
    chk("wr_sample", 32'(PROG_SAMPLE[15:8]), 32'hAA);

    // reset while a read is in ISSUE: no strobe, outputs cleared, voice 0 first after
    idle(4);
    REQ = 4'b1000; PHASE_IN[21 +: 7] = 7'd3; WAVE_SEL[6 +: 2] = 2'd2;
    tick();
    REQ = '0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_trig", 32'(TRIG_SAMPLE), 32'h0);
    chk("rst_samples", PROG_SAMPLE, 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst_no_strobe", 32'(TRIG_SAMPLE), 32'h0);
    end
    REQ = 4'hF;
    tick();
    REQ = '0;
    tick(); tick(); tick();
    chk("rst_first_voice0", 32'(TRIG_SAMPLE), 32'h1);
    idle(12);

    // sustained requests from every voice: each strobes every 12 cycles
    do_reset();
    for (int v = 0; v < NV; v++) begin
      last_s[v] = -1;
      cnt_s[v]  = 0;
    end
    REQ = 4'hF;
    for (int c = 0; c < 100; c++) begin
      PHASE_IN = 28'($urandom);
      WAVE_SEL = 8'($urandom);
      tick();
      for (int v = 0; v < NV; v++) begin
        if (TRIG_SAMPLE[v]) begin
          if (last_s[v] >= 0) chk("rr_gap", 32'(cyc - last_s[v]), 32'd12);
          last_s[v] = cyc;
          cnt_s[v]++;
        end
      end
    end
    idle(15);
    for (int v = 0; v < NV; v++) chk("rr_count", 32'(cnt_s[v] >= 7), 32'd1);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      RST      = ($urandom_range(0, 127) == 0);
      REQ      = 4'($urandom & $urandom);
      PHASE_IN = 28'($urandom);
      WAVE_SEL = 8'($urandom);
      WR_EN    = ($urandom_range(0, 7) == 0);
      WR_ADDR  = 9'($urandom);
      WR_DATA  = 8'($urandom);
      tick();
    end
    RST = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
